// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//   Memory bus between the datapath memory access unit and the memory system.
//
//   Signals
//     mem_req    : bus request, held until granted
//     mem_we     : write enable, meaningful while mem_req=1
//     mem_addr   : word-aligned byte address
//     mem_be     : byte lane enables
//     mem_wdata  : write data (byte stores replicated to all lanes)
//     mem_gnt    : memory accepts the request this cycle
//     mem_rvalid : read data valid this cycle
//     mem_rdata  : read data
//
//   Modports
//     master : the access unit (drives request side)
//     slave  : the memory (drives grant/response side)
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Bridges single-cycle datapath load/store requests onto a request/grant
//   memory bus with a separate read-valid response. Stalls the datapath while
//   an access is outstanding, supports word and byte accesses, flags misaligned
//   word accesses and bus timeouts with a one-cycle Fault pulse.
//
//   Parameters
//     TIMEOUT   : max cycles spent in REQ/WAIT before the access is aborted
//
//   Ports
//     clk       : clock, rising edge
//     reset     : asynchronous active-low reset
//     MemRead   : load request for the current instruction
//     MemWrite  : store request (wins over MemRead when both are set)
//     ByteOp    : 1 = byte access, 0 = word access
//     ALUResult : byte address
//     WriteData : store data
//     ReadData  : registered load data
//     Stall     : combinational hold request to PC / writeback
//     Fault     : one-cycle pulse on misaligned word access or timeout
//     bus       : memory bus (master side)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic                      ByteOp,
  input  logic [31:0]               ALUResult,
  input  logic [31:0]               WriteData,
  output logic [31:0]               ReadData,
  output logic                      Stall,
  output logic                      Fault,
  mem_access_unit_if.master         bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             fault_q, fault_d;

  logic        pending;
  logic        misaligned;
  logic [1:0]  lane;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  assign pending    = MemRead | MemWrite;
  assign lane       = ALUResult[1:0];
  // Only word accesses can be misaligned; any byte address is legal.
  assign misaligned = ~ByteOp & (lane != 2'b00);

  always_comb begin
    lane_byte = bus.mem_rdata[7:0];
    case (lane)
      2'd0: lane_byte = bus.mem_rdata[7:0];
      2'd1: lane_byte = bus.mem_rdata[15:8];
      2'd2: lane_byte = bus.mem_rdata[23:16];
      2'd3: lane_byte = bus.mem_rdata[31:24];
      default: lane_byte = bus.mem_rdata[7:0];
    endcase
  end

  assign load_data = ByteOp ? {24'h0, lane_byte} : bus.mem_rdata;

  // Request-side bus fields follow the datapath inputs directly; the datapath
  // holds them stable for as long as Stall is asserted.
  assign bus.mem_we    = MemWrite;
  assign bus.mem_addr  = {ALUResult[31:2], 2'b00};
  assign bus.mem_be    = ByteOp ? (4'b0001 << lane) : 4'hF;
  assign bus.mem_wdata = ByteOp ? {4{WriteData[7:0]}} : WriteData;

  assign ReadData = rdata_q;
  // fault_q is only ever set on the transition into DONE, and DONE lasts one
  // cycle, so it is already a one-cycle pulse.
  assign Fault    = fault_q;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    fault_d     = 1'b0;
    bus.mem_req = 1'b0;
    Stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending) begin
          if (misaligned) begin
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end

      REQ: begin
        bus.mem_req = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (bus.mem_gnt) begin
          if (MemWrite) begin
            state_d = DONE;
          end else if (bus.mem_rvalid) begin
            state_d = DONE;
            rdata_d = load_data;
          end else begin
            state_d = WAIT;
          end
        end else if (cnt_q >= CNT_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = 32'h0;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_rvalid) begin
          state_d = DONE;
          rdata_d = load_data;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = 32'h0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    Stall = pending && (state_q != DONE);
  end

  // NOTE: state is updated with non-blocking assignments only, and the
  // asynchronous reset clears every register including the load data, so a
  // transaction abandoned by reset can never leave stale data visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed testbench for mem_access_unit. Inputs change and outputs are
//   sampled shortly after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic        ByteOp;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Fault;

  int checks;
  int failures;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ByteOp    (ByteOp),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    ByteOp         = 1'b0;
    ALUResult      = 32'h0;
    WriteData      = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk); @(negedge clk); #1;
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rst_readdata got=%h exp=%h", ReadData, 32'h0); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", Fault); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", Stall); end
    reset = 1'b1;
  endtask

  // Word load 0x100: gnt in first REQ cycle, rvalid two cycles later.
  task automatic test_word_load();
    @(negedge clk); MemRead = 1'b1; ByteOp = 1'b0; ALUResult = 32'h100; #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL wl_stall_idle got=%b exp=1", Stall); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL wl_req_idle got=%b exp=0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h100) begin failures++; $display("FAIL wl_addr got=%h exp=%h", bus.mem_addr, 32'h100); end
    checks++; if (bus.mem_be !== 4'hF) begin failures++; $display("FAIL wl_be got=%h exp=f", bus.mem_be); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL wl_we got=%b exp=0", bus.mem_we); end
    @(negedge clk); bus.mem_gnt = 1'b1; #1;
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL wl_req_c1 got=%b exp=1", bus.mem_req); end
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL wl_stall_c1 got=%b exp=1", Stall); end
    @(negedge clk); bus.mem_gnt = 1'b0; #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL wl_req_wait got=%b exp=0", bus.mem_req); end
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL wl_stall_c2 got=%b exp=1", Stall); end
    @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678; #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL wl_stall_c3 got=%b exp=1", Stall); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL wl_stall_done got=%b exp=0", Stall); end
    checks++; if (ReadData !== 32'h12345678) begin failures++; $display("FAIL wl_readdata got=%h exp=%h", ReadData, 32'h12345678); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL wl_fault got=%b exp=0", Fault); end
    MemRead = 1'b0;
    @(negedge clk); #1;
    checks++; if (ReadData !== 32'h12345678) begin failures++; $display("FAIL wl_readdata_hold got=%h exp=%h", ReadData, 32'h12345678); end
  endtask

  // STRB to 0x203 with data 0xAB.
  task automatic test_strb();
    @(negedge clk); MemWrite = 1'b1; ByteOp = 1'b1; ALUResult = 32'h203; WriteData = 32'h000000AB; #1;
    checks++; if (bus.mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=%h", bus.mem_wdata, 32'hABABABAB); end
    checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h200) begin failures++; $display("FAIL sb_addr got=%h exp=%h", bus.mem_addr, 32'h200); end
    @(negedge clk); bus.mem_gnt = 1'b1; #1;
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL sb_req got=%b exp=1", bus.mem_req); end
    @(negedge clk); bus.mem_gnt = 1'b0; #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL sb_stall_done got=%b exp=0", Stall); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL sb_req_done got=%b exp=0", bus.mem_req); end
    checks++; if (ReadData !== 32'h12345678) begin failures++; $display("FAIL sb_readdata_kept got=%h exp=%h", ReadData, 32'h12345678); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL sb_fault got=%b exp=0", Fault); end
    MemWrite = 1'b0; ByteOp = 1'b0;
  endtask

  // LDRB from 0x102, gnt and rvalid together.
  task automatic test_ldrb();
    @(negedge clk); MemRead = 1'b1; ByteOp = 1'b1; ALUResult = 32'h102; #1;
    checks++; if (bus.mem_be !== 4'b0100) begin failures++; $display("FAIL lb_be got=%b exp=0100", bus.mem_be); end
    @(negedge clk); bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAABBCCDD; #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lb_stall_req got=%b exp=1", Stall); end
    @(negedge clk); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lb_stall_done got=%b exp=0", Stall); end
    checks++; if (ReadData !== 32'h000000BB) begin failures++; $display("FAIL lb_readdata got=%h exp=%h", ReadData, 32'h000000BB); end
    MemRead = 1'b0; ByteOp = 1'b0;
  endtask

  // MemRead and MemWrite together behave as a write: done right after gnt.
  task automatic test_read_write_both();
    @(negedge clk); MemRead = 1'b1; MemWrite = 1'b1; ALUResult = 32'h300; WriteData = 32'h55AA55AA; #1;
    checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rw_we got=%b exp=1", bus.mem_we); end
    checks++; if (bus.mem_wdata !== 32'h55AA55AA) begin failures++; $display("FAIL rw_wdata got=%h exp=%h", bus.mem_wdata, 32'h55AA55AA); end
    @(negedge clk); bus.mem_gnt = 1'b1; #1;
    @(negedge clk); bus.mem_gnt = 1'b0; #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rw_stall_done got=%b exp=0", Stall); end
    checks++; if (ReadData !== 32'h000000BB) begin failures++; $display("FAIL rw_readdata_kept got=%h exp=%h", ReadData, 32'h000000BB); end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Misaligned word load from 0x101.
  task automatic test_misaligned();
    @(negedge clk); MemRead = 1'b1; ByteOp = 1'b0; ALUResult = 32'h101; #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL ma_req_idle got=%b exp=0", bus.mem_req); end
    @(negedge clk); #1;
    checks++; if (Fault !== 1'b1) begin failures++; $display("FAIL ma_fault got=%b exp=1", Fault); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL ma_req_done got=%b exp=0", bus.mem_req); end
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL ma_readdata got=%h exp=%h", ReadData, 32'h0); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL ma_stall got=%b exp=0", Stall); end
    MemRead = 1'b0;
    @(negedge clk); #1;
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL ma_fault_pulse got=%b exp=0", Fault); end
  endtask

  // Bus responses while idle must not affect anything.
  task automatic test_ignore_idle();
    @(negedge clk); bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D; #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL ig_req got=%b exp=0", bus.mem_req); end
    @(negedge clk); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; #1;
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL ig_readdata got=%h exp=%h", ReadData, 32'h0); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL ig_fault got=%b exp=0", Fault); end
  endtask

  // Store that is never granted times out after 16 REQ cycles.
  task automatic test_timeout();
    int  req_cycles;
    bit  fault_seen;
    // Load a nonzero value first so the timeout clearing ReadData is visible.
    @(negedge clk); MemRead = 1'b1; ALUResult = 32'h104; #1;
    @(negedge clk); bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADF00D; #1;
    @(negedge clk); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; #1;
    checks++; if (ReadData !== 32'h0BADF00D) begin failures++; $display("FAIL to_preload got=%h exp=%h", ReadData, 32'h0BADF00D); end
    MemRead = 1'b0;
    @(negedge clk); MemWrite = 1'b1; ALUResult = 32'h200; WriteData = 32'h11223344; #1;
    req_cycles = 0;
    fault_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (Fault === 1'b1) begin
        fault_seen = 1'b1;
        break;
      end
      if (bus.mem_req === 1'b1) req_cycles++;
    end
    checks++; if (fault_seen !== 1'b1) begin failures++; $display("FAIL to_fault_seen got=%b exp=1", fault_seen); end
    checks++; if (req_cycles != 16) begin failures++; $display("FAIL to_req_cycles got=%0d exp=16", req_cycles); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL to_req_dropped got=%b exp=0", bus.mem_req); end
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL to_readdata got=%h exp=%h", ReadData, 32'h0); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL to_stall_done got=%b exp=0", Stall); end
    MemWrite = 1'b0;
    @(negedge clk); #1;
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL to_fault_after got=%b exp=0", Fault); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL to_req_idle got=%b exp=0", bus.mem_req); end
  endtask

  // Reset during WAIT abandons the load; a later rvalid is ignored.
  task automatic test_reset_mid_access();
    @(negedge clk); MemRead = 1'b1; ALUResult = 32'h400; #1;
    @(negedge clk); bus.mem_gnt = 1'b1; #1;
    @(negedge clk); bus.mem_gnt = 1'b0; #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rm_req_wait got=%b exp=0", bus.mem_req); end
    reset = 1'b0; #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rm_req_rst got=%b exp=0", bus.mem_req); end
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL rm_stall_rst got=%b exp=1", Stall); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL rm_fault_rst got=%b exp=0", Fault); end
    @(negedge clk); reset = 1'b1; MemRead = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #1;
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; #1;
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rm_no_capture got=%h exp=%h", ReadData, 32'h0); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rm_stall_idle got=%b exp=0", Stall); end
    MemRead = 1'b1; ALUResult = 32'h500; #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rm_restart_idle got=%b exp=0", bus.mem_req); end
    @(negedge clk); bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600DCAFE; #1;
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rm_restart_req got=%b exp=1", bus.mem_req); end
    @(negedge clk); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; #1;
    checks++; if (ReadData !== 32'h600DCAFE) begin failures++; $display("FAIL rm_restart_data got=%h exp=%h", ReadData, 32'h600DCAFE); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rm_restart_stall got=%b exp=0", Stall); end
    MemRead = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_word_load();
    test_strb();
    test_ldrb();
    test_read_write_both();
    test_misaligned();
    test_ignore_idle();
    test_timeout();
    test_reset_mid_access();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
